// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory-access stage over a byte-wide synchronous data RAM
//
// Purpose: performs LB/LH/LW/LBU/LHU loads and SB/SH/SW stores one byte per
// cycle, stalling the upstream pipeline until the access completes, and passes
// non-memory results straight through to the MEM/WB register.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   op_i               op code from EX/MEM
//   rd_addr_i          destination register
//   rd_data_i          ALU result or store data
//   mem_addr_i         effective address
//   mem_a/mem_wr/mem_dout  byte RAM address, write strobe, write byte
//   mem_din            read byte, valid one cycle after its address
//   rd_addr_o/rd_data_o    write-back register and value to MEM/WB
//   mem_stall          freeze upstream stages, MEM/WB loads a bubble
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   op_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  output logic [4:0]        rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              mem_stall
);

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LH  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LBU = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LHU = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SB  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SH  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(8);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_cnt;
  logic [1:0]  w_next_cnt;
  logic [31:0] r_buf;

  logic              w_is_load;
  logic              w_is_store;
  logic [1:0]        w_last;      // access size minus one
  logic [1:0]        w_cnt_inc;
  logic [DATA_W-1:0] w_load_val;

  assign w_cnt_inc = r_cnt + 2'd1;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_last     = 2'd0;
    case (op_i)
      OP_LB, OP_LBU: w_is_load = 1'b1;
      OP_LH, OP_LHU: begin w_is_load = 1'b1; w_last = 2'd1; end
      OP_LW:         begin w_is_load = 1'b1; w_last = 2'd3; end
      OP_SB:         w_is_store = 1'b1;
      OP_SH:         begin w_is_store = 1'b1; w_last = 2'd1; end
      OP_SW:         begin w_is_store = 1'b1; w_last = 2'd3; end
      default:       w_last = 2'd0;
    endcase
  end

  always_comb begin
    w_load_val = '0;
    case (op_i)
      OP_LB:   w_load_val = {{(DATA_W-8){r_buf[7]}}, r_buf[7:0]};
      OP_LH:   w_load_val = {{(DATA_W-16){r_buf[15]}}, r_buf[15:0]};
      OP_LBU:  w_load_val = {{(DATA_W-8){1'b0}}, r_buf[7:0]};
      OP_LHU:  w_load_val = {{(DATA_W-16){1'b0}}, r_buf[15:0]};
      default: w_load_val = DATA_W'(r_buf);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_buf   <= 32'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (r_state == S_READ) begin
        r_buf[{r_cnt, 3'b000} +: 8] <= mem_din;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    mem_a        = '0;
    mem_wr       = 1'b0;
    mem_dout     = 8'd0;
    mem_stall    = 1'b0;
    rd_addr_o    = 5'd0;
    rd_data_o    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_is_load) begin
          mem_a        = mem_addr_i;
          mem_stall    = 1'b1;
          w_next_state = S_READ;
          w_next_cnt   = 2'd0;
        end else if (w_is_store) begin
          mem_a        = mem_addr_i;
          mem_wr       = 1'b1;
          mem_dout     = rd_data_i[7:0];
          mem_stall    = 1'b1;
          w_next_state = (w_last == 2'd0) ? S_DONE : S_WRITE;
          w_next_cnt   = 2'd1;
        end else begin
          rd_addr_o = rd_addr_i;
          rd_data_o = rd_data_i;
        end
      end
      S_READ: begin
        // The byte captured this cycle was addressed last cycle; present the next one now.
        mem_stall = 1'b1;
        if (r_cnt != w_last) begin
          mem_a      = mem_addr_i + ADDR_W'(w_cnt_inc);
          w_next_cnt = w_cnt_inc;
        end else begin
          w_next_state = S_DONE;
        end
      end
      S_WRITE: begin
        mem_a     = mem_addr_i + ADDR_W'(r_cnt);
        mem_wr    = 1'b1;
        mem_dout  = rd_data_i[{r_cnt, 3'b000} +: 8];
        mem_stall = 1'b1;
        if (r_cnt == w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_cnt = w_cnt_inc;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 2'd0;
        if (w_is_load) begin
          rd_addr_o = rd_addr_i;
          rd_data_o = w_load_val;
        end
      end
    endcase
    // Outputs are forced quiet during reset so a store interrupted mid-way writes no further byte.
    if (rst) begin
      mem_a     = '0;
      mem_wr    = 1'b0;
      mem_dout  = 8'd0;
      mem_stall = 1'b0;
      rd_addr_o = 5'd0;
      rd_data_o = '0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking scoreboard bench for mem_stage
module tb_mem_stage;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_ADD = 4'd9;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        mem_stall;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          stalls;
  } exp_t;

  exp_t sb_q[$];
  logic [7:0] ram [logic [31:0]];

  mem_stage #(.ADDR_W(32), .DATA_W(32), .OP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_i       (op_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_i  (rd_data_i),
    .mem_addr_i (mem_addr_i),
    .mem_a      (mem_a),
    .mem_wr     (mem_wr),
    .mem_dout   (mem_dout),
    .mem_din    (mem_din),
    .rd_addr_o  (rd_addr_o),
    .rd_data_o  (rd_data_o),
    .mem_stall  (mem_stall)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: read data appears the cycle after its address.
  always @(posedge clk) begin
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [4:0] rd,
                        input logic [31:0] data, input logic [31:0] addr,
                        input logic [31:0] exp_data);
    int          n;
    bit          is_load;
    bit          is_store;
    bit          done;
    int          stalls;
    logic [31:0] a_log[$];
    exp_t        e;
    n        = op_size(op);
    is_load  = (op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU});
    is_store = (op inside {OP_SB, OP_SH, OP_SW});
    e.rd     = is_store ? 5'd0 : rd;
    e.data   = is_store ? 32'd0 : exp_data;
    e.stalls = is_load ? n + 1 : (is_store ? n : 0);
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    op_i = op; rd_addr_i = rd; rd_data_i = data; mem_addr_i = addr;
    done   = 1'b0;
    stalls = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!mem_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      a_log.push_back(mem_a);
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_rd_addr"}, 32'(rd_addr_o), 32'(e.rd));
      check({tag, "_rd_data"}, rd_data_o, e.data);
      check({tag, "_stalls"}, 32'(stalls), 32'(e.stalls));
      check({tag, "_wr_done"}, 32'(mem_wr), 32'd0);
      for (int k = 0; k < n && k < a_log.size(); k++)
        check($sformatf("%s_addr%0d", tag, k), a_log[k], addr + 32'(k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with a load presented: every output must stay quiet.
    rst = 1'b1; op_i = OP_LW; rd_addr_i = 5'd7; rd_data_i = 32'h55; mem_addr_i = 32'h40;
    @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_wr", 32'(mem_wr), 32'd0);
    check("rst_a", mem_a, 32'd0);
    check("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    check("rst_rd_data", rd_data_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; op_i = OP_NOP; rd_addr_i = 5'd0; rd_data_i = 32'd0; mem_addr_i = 32'd0;

    run_op("add",  OP_ADD, 5'd5,  32'h12345678, 32'h0,        32'h12345678);
    run_op("nop",  OP_NOP, 5'd9,  32'hCAFEF00D, 32'h100,      32'hCAFEF00D);
    run_op("sw",   OP_SW,  5'd3,  32'hDEADBEEF, 32'h100,      32'h0);
    check("ram_100", 32'(ram_rd(32'h100)), 32'hEF);
    check("ram_101", 32'(ram_rd(32'h101)), 32'hBE);
    check("ram_102", 32'(ram_rd(32'h102)), 32'hAD);
    check("ram_103", 32'(ram_rd(32'h103)), 32'hDE);
    run_op("lw",   OP_LW,  5'd10, 32'h0,        32'h100,      32'hDEADBEEF);
    run_op("lb",   OP_LB,  5'd11, 32'h0,        32'h103,      32'hFFFFFFDE);
    run_op("lbu",  OP_LBU, 5'd12, 32'h0,        32'h103,      32'h000000DE);
    run_op("lh",   OP_LH,  5'd13, 32'h0,        32'h102,      32'hFFFFDEAD);
    run_op("lhu",  OP_LHU, 5'd14, 32'h0,        32'h102,      32'h0000DEAD);
    run_op("sh",   OP_SH,  5'd1,  32'h7777A1B2, 32'hFFFFFFFF, 32'h0);
    check("ram_wrap_hi", 32'(ram_rd(32'hFFFFFFFF)), 32'hB2);
    check("ram_wrap_lo", 32'(ram_rd(32'h00000000)), 32'hA1);
    run_op("lh_wrap", OP_LH, 5'd15, 32'h0,      32'hFFFFFFFF, 32'hFFFFA1B2);
    run_op("lb_pos", OP_LB, 5'd16, 32'h0,       32'h101,      32'hFFFFFFBE);
    run_op("sb",   OP_SB,  5'd2,  32'h1234565A, 32'h300,      32'h0);
    run_op("lbu_b2b", OP_LBU, 5'd20, 32'h0,     32'h300,      32'h0000005A);
    run_op("add2", OP_ADD, 5'd31, 32'h80000001, 32'h300,      32'h80000001);

    // Reset in the third byte of a word store: only bytes 0-1 may land.
    @(posedge clk);
    #1;
    op_i = OP_SW; rd_addr_i = 5'd4; rd_data_i = 32'h11223344; mem_addr_i = 32'h200;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_wr_in_rst", 32'(mem_wr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; op_i = OP_NOP; rd_addr_i = 5'd0; rd_data_i = 32'd0; mem_addr_i = 32'd0;
    @(negedge clk);
    check("rstmid_stall", 32'(mem_stall), 32'd0);
    check("rstmid_wr", 32'(mem_wr), 32'd0);
    check("rstmid_a", mem_a, 32'd0);
    check("rstmid_dout", 32'(mem_dout), 32'd0);
    check("rstmid_rd_addr", 32'(rd_addr_o), 32'd0);
    check("rstmid_rd_data", rd_data_o, 32'd0);
    check("rstmid_ram0", 32'(ram_rd(32'h200)), 32'h44);
    check("rstmid_ram1", 32'(ram_rd(32'h201)), 32'h33);
    check("rstmid_ram2", 32'(ram_rd(32'h202)), 32'h00);
    check("rstmid_ram3", 32'(ram_rd(32'h203)), 32'h00);

    // The stage must be back in IDLE and able to run a fresh access.
    run_op("lhu_after_rst", OP_LHU, 5'd6, 32'h0, 32'h200, 32'h00003344);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the RV32I pipeline. Sits directly downstream of the execute stage's EX/MEM register.
- Consumes the op, the effective address, the store data / ALU result and the destination register. Performs loads and stores over a byte-wide synchronous data RAM port.
- Hands the write-back value and destination register to the MEM/WB register.
- Holds the pipeline via mem_stall while a multi-byte access is in progress.

Parameters:
- ADDR_W, 32, width of the effective address and RAM address.
- DATA_W, 32, register and data width.
- OP_W, `OpLen, width of the internal op code. Op values are the shared config.v macros: LB, LH, LW, LBU, LHU, SB, SH, SW, NOP.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- op_i  in  OP_W  op from EX/MEM register.
- rd_addr_i  in  5  destination register (loads / ALU ops).
- rd_data_i  in  DATA_W  ALU result, or store data for SB/SH/SW.
- mem_addr_i  in  ADDR_W  effective address for loads and stores.
- mem_a  out  ADDR_W  byte address to data RAM.
- mem_wr  out  1  1 = write byte this cycle.
- mem_dout  out  8  byte to write.
- mem_din  in  8  read byte, valid the cycle after its address was presented.
- rd_addr_o  out  5  destination register to MEM/WB.
- rd_data_o  out  DATA_W  write-back value to MEM/WB.
- mem_stall  out  1  1 = freeze PC, IF/ID, ID/EX and EX/MEM; MEM/WB loads a bubble.

Behaviour:
- Reset (any cycle, including mid-access):
  - Return to IDLE; byte counter and assembly buffer cleared.
  - All outputs 0: mem_wr=0, mem_a=0, mem_dout=0, mem_stall=0, rd_addr_o=0, rd_data_o=0.
  - A partially written store is abandoned; bytes already written stay written.
- Access size N: LB/LBU/SB=1, LH/LHU/SH=2, LW/SW=4.
- Byte order is little-endian. Byte k lives at mem_addr_i+k, computed modulo 2^ADDR_W (0xFFFFFFFF+1 wraps to 0). No alignment check; misaligned accesses are performed bytewise.
- Non-memory ops (including NOP):
  - Stay in IDLE; mem_stall=0; mem_wr=0.
  - rd_addr_o=rd_addr_i and rd_data_o=rd_data_i, combinationally.
- Upstream holds op_i, rd_addr_i, rd_data_i and mem_addr_i stable while mem_stall=1. The block does not re-latch them.
- FSM states: IDLE, READ, WRITE, DONE. Counter cnt is 2 bits.
- IDLE with a load op:
  - mem_a=mem_addr_i, mem_wr=0, mem_stall=1.
  - Next: READ, cnt=0.
- READ:
  - Capture mem_din into buffer byte cnt.
  - If cnt<N-1: mem_a=mem_addr_i+cnt+1, cnt++, stay in READ.
  - If cnt=N-1: go to DONE.
  - mem_stall=1 throughout.
- IDLE with a store op:
  - mem_a=mem_addr_i, mem_wr=1, mem_dout=rd_data_i[7:0], mem_stall=1.
  - Next: DONE if N=1, else WRITE with cnt=1.
- WRITE:
  - mem_a=mem_addr_i+cnt, mem_wr=1, mem_dout=rd_data_i[8*cnt+7:8*cnt], mem_stall=1.
  - If cnt=N-1 go to DONE, else cnt++.
- DONE (one cycle): mem_stall=0, mem_wr=0, then IDLE.
  - Loads: rd_addr_o=rd_addr_i. rd_data_o is the assembled value, sign-extended for LB/LH and zero-extended for LBU/LHU/LW.
  - Stores: rd_addr_o=0, rd_data_o=0.
  - The pipeline advances at the end of DONE. The next IDLE cycle sees the next op, so back-to-back memory ops incur no extra bubble beyond their own stall.
- While mem_stall=1: rd_addr_o=0 and rd_data_o=0, so MEM/WB captures a bubble.
- Latency (cycles the instruction occupies the stage, including the DONE cycle):
  - Loads: N+2, of which N+1 are stalled.
  - Stores: N+1 (SB=2, SW=5).
- mem_a, mem_wr and mem_dout are combinational from state, cnt and the held inputs.
- mem_wr is never 1 outside IDLE-with-store or WRITE.

Test Plan:
- Reset mid-access: reset asserted in WRITE after 2 bytes of an SW → next cycle IDLE, mem_wr=0, mem_stall=0, all outputs 0. RAM holds only bytes 0–1 of the store.
- ADD passthrough, rd_addr_i=5, rd_data_i=0x12345678 → same cycle rd_addr_o=5, rd_data_o=0x12345678, mem_stall=0, mem_wr=0.
- SW 0xDEADBEEF to 0x100 → writes 0xEF,0xBE,0xAD,0xDE to 0x100..0x103 on consecutive cycles. mem_stall high 4 cycles, DONE on cycle 5 with rd_addr_o=0.
- LW from 0x100 after the store → mem_a sequence 0x100,0x101,0x102,0x103. Stall 5 cycles; DONE rd_data_o=0xDEADBEEF.
- LB 0x103 (byte 0xDE) → rd_data_o=0xFFFFFFDE. LBU 0x103 → 0x000000DE. LH 0x102 → 0xFFFFDEAD. LHU 0x102 → 0x0000DEAD.
- Address wrap: SH 0xA1B2 to 0xFFFFFFFF → byte 0xB2 at 0xFFFFFFFF, byte 0xA1 at 0x00000000.
- Back-to-back SB then LBU same address → LBU issues its address in the cycle right after SB's DONE and returns the stored byte zero-extended.
